// File: rtl/freq_meter_pkg.sv
// freq_meter shared definitions: FSM state encoding and
// default timing constants.
package freq_meter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int CLK_HZ              = 50000000;
  localparam int GATE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_MEASURE = ST_MEASURE,
    S_DONE    = ST_DONE
  } state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer plus delay flop for an async input;
// emits a one-cycle rise pulse on each synchronized 0->1.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  // synchronizer chain and edge-detect delay stage
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rises over GATE_CYCLES
// clocks. FREQ_METER_CONTINUOUS_EN re-arms after each window.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int COUNT_W     = 18
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               start,
  input  logic               sig_in,
  output logic               busy,
  output logic               valid,
  output logic [COUNT_W-1:0] count_out,
  output logic               overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t             state;
  logic [GW-1:0]      gate_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               ovf_int;
  logic               rise;
  logic [COUNT_W-1:0] edge_nxt;
  logic               ovf_nxt;

  sync_rise_detect u_sync (
    .clk   (clock_in),
    .reset (reset),
    .d     (sig_in),
    .rise  (rise)
  );

  // saturating edge count including this cycle's rise
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_int;
    if (rise) begin
      if (&edge_cnt) ovf_nxt  = 1'b1;
      else           edge_nxt = edge_cnt + COUNT_W'(1);
    end
  end

  // measurement FSM with gate and edge counters
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= S_IDLE;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      ovf_int   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_MEASURE;
            busy     <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
          end
        end
        S_MEASURE: begin
          gate_cnt <= gate_cnt + GW'(1);
          edge_cnt <= edge_nxt;
          ovf_int  <= ovf_nxt;
          if (gate_cnt == GATE_LAST) begin
            count_out <= edge_nxt;
            overflow  <= ovf_nxt;
            valid     <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
          state    <= S_MEASURE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf_int  <= 1'b0;
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter against a sampled-history
// edge-count model; covers single-shot and continuous builds.
module tb_freq_meter;

  localparam int G = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sig_in = 1'b0;
  logic        busy, valid, ovf;
  logic [17:0] cnt;
  logic        busy4, valid4, ovf4;
  logic [3:0]  cnt4;

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(18)) dut (
    .clock_in  (clk),
    .reset     (reset),
    .start     (start),
    .sig_in    (sig_in),
    .busy      (busy),
    .valid     (valid),
    .count_out (cnt),
    .overflow  (ovf)
  );

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(4)) dut4 (
    .clock_in  (clk),
    .reset     (reset),
    .start     (start),
    .sig_in    (sig_in),
    .busy      (busy4),
    .valid     (valid4),
    .count_out (cnt4),
    .overflow  (ovf4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit hist [16384];

  // sig_in as sampled at each rising edge, indexed by edge
  always @(posedge clk) begin
    if (cyc < 16384) hist[cyc] <= sig_in;
    cyc <= cyc + 1;
  end

  int half_per = 0;
  int ph_cnt = 0;

  // square wave generator, toggles every half_per clocks
  always @(posedge clk) begin
    #1;
    if (half_per == 0) begin
      sig_in = 1'b0;
      ph_cnt = 0;
    end else if (ph_cnt >= half_per - 1) begin
      sig_in = ~sig_in;
      ph_cnt = 0;
    end else begin
      ph_cnt++;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // rises seen by the meter for a window armed at edge c0:
  // edge c0+j uses samples c0+j-2 (new) and c0+j-3 (old)
  function automatic int model_edges(input int c0);
    int n = 0;
    for (int j = 1; j <= G; j++)
      if (hist[c0+j-2] && !hist[c0+j-3]) n++;
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic set_sig(input int hp);
    half_per = hp;
    repeat (6) @(posedge clk);
  endtask

  task automatic do_start(output int c0);
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    c0 = cyc;
    #2 start = 1'b0;
  endtask

  task automatic chk_counts(input int n);
    chk("count18", cnt, sat(n, 18));
    chk("ovf18", ovf, (n > 262143) ? 1 : 0);
    chk("count4", cnt4, sat(n, 4));
    chk("ovf4", ovf4, (n > 15) ? 1 : 0);
  endtask

  task automatic run_window(input int hp, input int exp_cnt,
                            input bit extra);
    int c0;
    int lat = -1;
    int bcnt = 0;
    int nval = 0;
    int n;
    set_sig(hp);
    do_start(c0);
    for (int k = 0; k <= G + 4; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (valid) begin
        nval++;
        if (lat < 0) begin
          lat = k + 1;
          chk_counts(model_edges(c0));
          if (exp_cnt >= 0) chk("spec_count", cnt, exp_cnt);
        end
      end
      if (extra) begin
        if (k == 49 || k == G) start = 1'b1;
        if (k == 50 || k == G + 1) start = 1'b0;
      end
    end
    n = model_edges(c0);
    chk("latency", lat, G + 1);
    chk("busy_cycles", bcnt, G + 1);
    chk("valid_pulses", nval, 1);
    chk("count_hold", cnt, sat(n, 18));
  endtask

  task automatic run_abort();
    int c0;
    int nval = 0;
    set_sig(5);
    do_start(c0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 39) reset = 1'b1;
    end
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_count", cnt, 0);
    chk("abort_ovf", ovf, 0);
    reset = 1'b0;
    repeat (G + 10) begin
      @(negedge clk);
      if (valid) nval++;
    end
    chk("abort_no_valid", nval, 0);
  endtask

  task automatic run_cont(input int hp, input int exp_cnt);
    int c0;
    int idx = 0;
    int idle = 0;
    set_sig(hp);
    do_start(c0);
    for (int k = 0; k <= 3 * (G + 1) + 2; k++) begin
      @(negedge clk);
      if (!busy) idle++;
      if (valid && idx < 3) begin
        chk("cont_valid_at", k, G + idx * (G + 1));
        chk_counts(model_edges(c0 + idx * (G + 1)));
        if (exp_cnt >= 0) chk("cont_spec", cnt, exp_cnt);
        idx++;
      end
    end
    chk("cont_valids", idx, 3);
    chk("cont_busy", idle, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("cont_stop_busy", busy, 0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;
`ifdef FREQ_METER_CONTINUOUS_EN
    run_cont(5, 10);
    run_cont(2, 25);
    repeat (2) run_cont(int'($urandom_range(2, 12)), -1);
`else
    run_window(5, 10, 1'b0);
    run_window(2, 25, 1'b0);
    run_window(0, 0, 1'b0);
    run_window(5, 10, 1'b1);
    run_abort();
    run_window(5, 10, 1'b0);
    repeat (8)
      run_window(int'($urandom_range(2, 12)), -1,
                 1'($urandom_range(0, 1)));
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
